// File: rtl/output_port_arbiter.sv
// Wormhole output-port arbiter: round-robin grant on head flits,
// grant held until the packet's tail flit transfers.
module output_port_arbiter #(
  parameter  int N_INPUTS = 5,
  localparam int IDX_W    = $clog2(N_INPUTS)
) (
  input  logic                clk,
  input  logic                arst,
  input  logic [N_INPUTS-1:0] req_i,
  input  logic [N_INPUTS-1:0] head_i,
  input  logic [N_INPUTS-1:0] tail_i,
  input  logic                out_ready_i,
  output logic [N_INPUTS-1:0] grant_o,
  output logic                out_valid_o,
  output logic [IDX_W-1:0]    sel_o,
  output logic                locked_o,
  output logic                err_o
);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic              first_q, first_d;
  logic              err_q, err_d;

  logic [N_INPUTS-1:0] cand;
  logic                win_found;
  logic [IDX_W-1:0]    win_idx;
  logic                xfer;
  logic [IDX_W-1:0]    owner_nxt;

  // State register; first_q marks that the packet's first flit is pending
  always_ff @(posedge clk) begin
    if (arst) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_ptr_q <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

  // Round-robin search over head requests starting at rr_ptr
  always_comb begin
    cand      = req_i & head_i;
    win_found = 1'b0;
    win_idx   = '0;
    for (int k = 0; k < N_INPUTS; k++) begin
      int j;
      j = int'(rr_ptr_q) + k;
      if (j >= N_INPUTS) j = j - N_INPUTS;
      if (!win_found && cand[j]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(j);
      end
    end
  end

  // Next-state: lock on winner, release after tail transfer
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    first_d  = first_q;
    err_d    = 1'b0;
    xfer     = (state_q == LOCKED) && req_i[owner_q] && out_ready_i;
    owner_nxt = (owner_q == IDX_W'(N_INPUTS - 1)) ? '0 : owner_q + 1'b1;
    unique case (state_q)
      IDLE: begin
        if (|(req_i & ~head_i)) err_d = 1'b1;
        if (win_found) begin
          state_d = LOCKED;
          owner_d = win_idx;
          first_d = 1'b1;
        end
      end
      LOCKED: begin
        if (xfer) begin
          first_d = 1'b0;
          if (head_i[owner_q] && !tail_i[owner_q] && !first_q)
            err_d = 1'b1;
          if (tail_i[owner_q]) begin
            state_d  = IDLE;
            rr_ptr_d = owner_nxt;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs; forced quiet while reset is asserted so nothing transfers
  always_comb begin
    grant_o     = '0;
    out_valid_o = 1'b0;
    locked_o    = 1'b0;
    sel_o       = '0;
    err_o       = err_q;
    if (!arst) begin
      sel_o    = owner_q;
      locked_o = (state_q == LOCKED);
      if (state_q == LOCKED) begin
        out_valid_o = req_i[owner_q];
        if (req_i[owner_q] && out_ready_i)
          grant_o = N_INPUTS'(1) << owner_q;
      end
    end
  end

endmodule

// File: tb/tb_output_port_arbiter.sv
// Directed bench for output_port_arbiter: arbitration order,
// wormhole hold, backpressure, reset mid-packet, protocol errors.
module tb_output_port_arbiter;

  logic       clk = 1'b0;
  logic       arst;
  logic [4:0] req_i, head_i, tail_i;
  logic       out_ready_i;
  logic [4:0] grant_o;
  logic       out_valid_o;
  logic [2:0] sel_o;
  logic       locked_o;
  logic       err_o;

  int ncmp  = 0;
  int nfail = 0;

  output_port_arbiter #(.N_INPUTS(5)) dut (
    .clk        (clk),
    .arst       (arst),
    .req_i      (req_i),
    .head_i     (head_i),
    .tail_i     (tail_i),
    .out_ready_i(out_ready_i),
    .grant_o    (grant_o),
    .out_valid_o(out_valid_o),
    .sel_o      (sel_o),
    .locked_o   (locked_o),
    .err_o      (err_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive inputs at the falling edge, check outputs 1 time unit later
  task automatic step(input string tag, input logic a,
                      input logic [4:0] r, input logic [4:0] h,
                      input logic [4:0] t, input logic rdy,
                      input logic [4:0] g, input logic v,
                      input logic l, input logic [2:0] s,
                      input logic e);
    @(negedge clk);
    arst = a;
    req_i = r;
    head_i = h;
    tail_i = t;
    out_ready_i = rdy;
    #1;
    chk({tag, ".grant"}, 8'(grant_o), 8'(g));
    chk({tag, ".valid"}, 8'(out_valid_o), 8'(v));
    chk({tag, ".locked"}, 8'(locked_o), 8'(l));
    chk({tag, ".sel"}, 8'(sel_o), 8'(s));
    chk({tag, ".err"}, 8'(err_o), 8'(e));
    chk({tag, ".inv_oh"}, 8'($onehot0(grant_o)), 8'd1);
    chk({tag, ".inv_gl"}, 8'(!(|grant_o) || locked_o), 8'd1);
    chk({tag, ".inv_vl"}, 8'(!out_valid_o || locked_o), 8'd1);
  endtask

  initial begin
    arst = 1'b1;
    req_i = '0;
    head_i = '0;
    tail_i = '0;
    out_ready_i = 1'b1;

    step("rst", 1, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);

    // North sends a 3-flit packet
    step("n_idle", 0, 5'b00001, 5'b00001, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    step("n_head", 0, 5'b00001, 5'b00001, 5'b00000, 1, 5'b00001, 1, 1, 0, 0);
    step("n_body", 0, 5'b00001, 5'b00000, 5'b00000, 1, 5'b00001, 1, 1, 0, 0);
    step("n_tail", 0, 5'b00001, 5'b00000, 5'b00001, 1, 5'b00001, 1, 1, 0, 0);
    step("n_done", 0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);

    // All inputs with single-flit packets from reset: order 0,1,2,3,4,0
    step("rr_rst", 1, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    for (int k = 0; k < 6; k++) begin
      step("rr_idle", 0, 5'b11111, 5'b11111, 5'b11111, 1,
           5'b00000, 0, 0, (k == 0) ? 3'd0 : 3'((k - 1) % 5), 0);
      step("rr_grant", 0, 5'b11111, 5'b11111, 5'b11111, 1,
           5'(1 << (k % 5)), 1, 1, 3'(k % 5), 0);
    end

    // Input 2 holds the port for 4 flits while input 0 waits
    step("w_idle", 0, 5'b00100, 5'b00100, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    step("w_head", 0, 5'b00101, 5'b00101, 5'b00000, 1, 5'b00100, 1, 1, 2, 0);
    step("w_b1", 0, 5'b00101, 5'b00001, 5'b00000, 1, 5'b00100, 1, 1, 2, 0);
    step("w_b2", 0, 5'b00101, 5'b00001, 5'b00000, 1, 5'b00100, 1, 1, 2, 0);
    step("w_tail", 0, 5'b00101, 5'b00001, 5'b00100, 1, 5'b00100, 1, 1, 2, 0);
    step("w_arb3", 0, 5'b01001, 5'b01001, 5'b01001, 1, 5'b00000, 0, 0, 2, 0);
    step("w_g3", 0, 5'b01001, 5'b01001, 5'b01001, 1, 5'b01000, 1, 1, 3, 0);
    step("w_arb0", 0, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00000, 0, 0, 3, 0);
    step("w_g0", 0, 5'b00001, 5'b00001, 5'b00001, 1, 5'b00001, 1, 1, 0, 0);

    // Backpressure then bubbles inside an input-1 packet
    step("b_idle", 0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    step("b_head", 0, 5'b00010, 5'b00010, 5'b00000, 1, 5'b00010, 1, 1, 1, 0);
    for (int k = 0; k < 3; k++)
      step("b_stall", 0, 5'b00010, 5'b00000, 5'b00000, 0,
           5'b00000, 1, 1, 1, 0);
    for (int k = 0; k < 2; k++)
      step("b_bubble", 0, 5'b00000, 5'b00000, 5'b00000, 1,
           5'b00000, 0, 1, 1, 0);
    step("b_body", 0, 5'b00010, 5'b00000, 5'b00000, 1, 5'b00010, 1, 1, 1, 0);
    step("b_tail", 0, 5'b00010, 5'b00000, 5'b00010, 1, 5'b00010, 1, 1, 1, 0);

    // Reset after 2 of 5 flits from input 3, then input 4 wins
    step("r_idle", 0, 5'b01000, 5'b01000, 5'b00000, 1, 5'b00000, 0, 0, 1, 0);
    step("r_f1", 0, 5'b01000, 5'b01000, 5'b00000, 1, 5'b01000, 1, 1, 3, 0);
    step("r_f2", 0, 5'b01000, 5'b00000, 5'b00000, 1, 5'b01000, 1, 1, 3, 0);
    step("r_rst", 1, 5'b01000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    step("r_idle4", 0, 5'b10000, 5'b10000, 5'b10000, 1, 5'b00000, 0, 0, 0, 0);
    step("r_g4", 0, 5'b10000, 5'b10000, 5'b10000, 1, 5'b10000, 1, 1, 4, 0);
    // Pointer wrapped to 0: input 0 beats input 1
    step("r_wrap", 0, 5'b00011, 5'b00011, 5'b00011, 1, 5'b00000, 0, 0, 4, 0);
    step("r_g0", 0, 5'b00011, 5'b00011, 5'b00011, 1, 5'b00001, 1, 1, 0, 0);

    // Body flit in IDLE: error pulse, no lock
    step("e_body", 0, 5'b00100, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    step("e_pulse", 0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 1);
    step("e_clr", 0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    // Second head inside a packet: still forwarded, error pulses
    step("e_idle", 0, 5'b00001, 5'b00001, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);
    step("e_head", 0, 5'b00001, 5'b00001, 5'b00000, 1, 5'b00001, 1, 1, 0, 0);
    step("e_head2", 0, 5'b00001, 5'b00001, 5'b00000, 1, 5'b00001, 1, 1, 0, 0);
    step("e_tail", 0, 5'b00001, 5'b00000, 5'b00001, 1, 5'b00001, 1, 1, 0, 1);
    step("e_end", 0, 5'b00000, 5'b00000, 5'b00000, 1, 5'b00000, 0, 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
